// File: rtl/cache.sv
// rtl/cache.sv - direct-mapped read-only instruction cache, four-word lines, one-cycle refill
module cache #(
    parameter int NUM_LINES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [31:0]  address,
    input  logic [127:0] dataline,
    output logic [31:0]  Ins,
    output logic         hit
);

    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = 28 - INDEX_BITS;

    logic                  valid      [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_store  [NUM_LINES];
    logic [127:0]          data_store [NUM_LINES];

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word_sel;
    logic [1:0]            unused_byte_offset;

    assign unused_byte_offset = address[1:0];
    assign word_sel           = address[3:2];
    assign index              = address[3+INDEX_BITS:4];
    assign tag                = address[31:4+INDEX_BITS];

    // Lookup is purely combinational so a hit costs no clock cycle.
    always_comb begin
        hit = valid[index] && (tag_store[index] == tag);
        Ins = 32'h0;
        if (hit) begin
            Ins = data_store[index][32*word_sel +: 32];
        end
    end

    // A miss edge overwrites the indexed line; there is no dirty state to write back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                valid[k]      <= 1'b0;
                tag_store[k]  <= '0;
                data_store[k] <= '0;
            end
        end else if (!hit) begin
            valid[index]      <= 1'b1;
            tag_store[index]  <= tag;
            data_store[index] <= dataline;
        end
    end

endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed self-checking bench for the instruction cache
module tb_cache;

    logic         CLK;
    logic         RST;
    logic [31:0]  address;
    logic [127:0] dataline;
    logic [31:0]  Ins;
    logic         hit;

    int checks;
    int errors;

    cache #(.NUM_LINES(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .address  (address),
        .dataline (dataline),
        .Ins      (Ins),
        .hit      (hit)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #3;
        RST = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        RST      = 1'b1;
        address  = 32'h0;
        dataline = '0;
        #12;

        // 1: reset state, then refill with unknown data still marks the line valid
        check("rst_hit", {31'b0, hit}, 32'h0);
        check("rst_ins", Ins, 32'h0);
        RST      = 1'b0;
        dataline = 'x;
        step();
        check("x_refill_hit", {31'b0, hit}, 32'h1);

        // 2: basic refill and word select
        do_reset();
        dataline = 128'h44444444_33333333_22222222_11111111;
        address  = 32'h0;
        #1;
        check("miss0_hit", {31'b0, hit}, 32'h0);
        check("miss0_ins", Ins, 32'h0);
        step();
        check("fill0_hit", {31'b0, hit}, 32'h1);
        check("w0", Ins, 32'h11111111);
        address = 32'h4;  #1; check("w1_hit", {31'b0, hit}, 32'h1); check("w1", Ins, 32'h22222222);
        address = 32'h8;  #1; check("w2", Ins, 32'h33333333);
        address = 32'hC;  #1; check("w3", Ins, 32'h44444444);

        // 3: unaligned addresses read the containing word
        address = 32'h1;  #1; check("ua1_hit", {31'b0, hit}, 32'h1); check("ua1", Ins, 32'h11111111);
        address = 32'h6;  #1; check("ua6", Ins, 32'h22222222);

        // 4: another index fills independently
        address = 32'h14; #1;
        check("idx1_miss", {31'b0, hit}, 32'h0);
        dataline = 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000;
        step();
        check("idx1_hit", {31'b0, hit}, 32'h1);
        check("idx1_w1", Ins, 32'hBBBB0000);
        address = 32'h0;  #1;
        check("idx0_keep_hit", {31'b0, hit}, 32'h1);
        check("idx0_keep", Ins, 32'h11111111);

        // 5: conflicting tag at index 0 evicts the old line
        address = 32'h100; #1;
        check("conf_miss", {31'b0, hit}, 32'h0);
        dataline = {96'h0, 32'hCAFEBABE};
        step();
        check("conf_hit", {31'b0, hit}, 32'h1);
        check("conf_ins", Ins, 32'hCAFEBABE);
        address = 32'h0;  #1;
        check("evicted_hit", {31'b0, hit}, 32'h0);
        check("evicted_ins", Ins, 32'h0);

        // 6: asynchronous reset between edges, and no refill while held
        address = 32'h14; #1;
        check("pre_rst_hit", {31'b0, hit}, 32'h1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("async_rst_hit", {31'b0, hit}, 32'h0);
        check("async_rst_ins", Ins, 32'h0);
        step();
        check("rst_edge_hit", {31'b0, hit}, 32'h0);
        #2;
        RST = 1'b0;
        #1;
        check("post_rst_hit", {31'b0, hit}, 32'h0);
        check("post_rst_ins", Ins, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
